// File: rtl/control_register_write_controller.sv
// Sequences CR0-CR7 register file writes for the paging, task-switch and execute units,
// including the TLB and pipeline flush handshakes that CR0/CR3 changes require.
module control_register_write_controller #(
  parameter bit         TLB_FLUSH_ON_PG = 1'b1,
  parameter logic [3:0] LMSW_MASK       = 4'hF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] cr0_current,
  input  logic [31:0] cr3_current,
  input  logic        pf_req,
  input  logic [31:0] pf_addr,
  output logic        pf_ack,
  input  logic        ts_req,
  input  logic [31:0] ts_cr3,
  output logic        ts_ack,
  input  logic        ex_req,
  input  logic [1:0]  ex_op,
  input  logic [2:0]  ex_index,
  input  logic [31:0] ex_data,
  output logic        ex_ack,
  output logic        ex_fault,
  output logic        cr_write_enable,
  output logic [2:0]  cr_write_index,
  output logic [31:0] cr_write_data,
  output logic        tlb_flush_req,
  input  logic        tlb_flush_ack,
  output logic        pipe_flush_req,
  input  logic        pipe_flush_ack,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, WRITE, TLB, PIPE, DONE} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_PF, SRC_TS, SRC_EX} src_t;

  localparam logic [1:0] OP_MOV  = 2'b00;
  localparam logic [1:0] OP_CLTS = 2'b01;
  localparam logic [1:0] OP_LMSW = 2'b10;

  state_t      state, state_next;
  src_t        src_q, grant_src;
  logic        tlb_q, pipe_q, fault_q;
  logic        grant_tlb, grant_pipe, grant_fault;
  logic [2:0]  index_q, grant_index;
  logic [31:0] data_q, grant_data;
  logic [31:0] lmsw_data;
  logic        pe_change, pg_change;
  logic        unused_bits;

  // CR3 low bits never reach the register file, so they take no part in decisions
  assign unused_bits = ^{cr3_current[11:0], ts_cr3[11:0]};

  assign pe_change = ex_data[0] ^ cr0_current[0];
  assign pg_change = ex_data[31] ^ cr0_current[31];

  // LMSW may set PE but can never clear it
  always_comb begin
    lmsw_data = cr0_current;
    for (int i = 0; i < 4; i++) begin
      if (LMSW_MASK[i]) lmsw_data[i] = ex_data[i];
    end
    if (LMSW_MASK[0]) lmsw_data[0] = ex_data[0] | cr0_current[0];
  end

  // Fixed-priority grant and write-image decode, evaluated only while IDLE
  always_comb begin
    grant_src   = SRC_NONE;
    grant_index = 3'd0;
    grant_data  = 32'd0;
    grant_tlb   = 1'b0;
    grant_pipe  = 1'b0;
    grant_fault = 1'b0;
    if (pf_req) begin
      grant_src   = SRC_PF;
      grant_index = 3'd2;
      grant_data  = pf_addr;
    end else if (ts_req) begin
      grant_src   = SRC_TS;
      grant_index = 3'd3;
      grant_data  = {ts_cr3[31:12], 12'd0};
      grant_tlb   = (ts_cr3[31:12] != cr3_current[31:12]);
    end else if (ex_req) begin
      grant_src = SRC_EX;
      case (ex_op)
        OP_MOV: begin
          case (ex_index)
            3'd0: begin
              grant_data = ex_data;
              grant_pipe = pe_change | pg_change;
              grant_tlb  = TLB_FLUSH_ON_PG & pg_change;
            end
            3'd2: begin
              grant_index = 3'd2;
              grant_data  = ex_data;
            end
            3'd3: begin
              grant_index = 3'd3;
              grant_data  = {ex_data[31:12], 12'd0};
              grant_tlb   = 1'b1;
            end
            default: grant_fault = 1'b1;
          endcase
        end
        OP_CLTS: grant_data = cr0_current & ~32'h0000_0008;
        OP_LMSW: begin
          grant_data = lmsw_data;
          grant_pipe = lmsw_data[0] ^ cr0_current[0];
        end
        default: grant_fault = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (grant_src != SRC_NONE) state_next = grant_fault ? DONE : WRITE;
      WRITE: state_next = tlb_q ? TLB : (pipe_q ? PIPE : DONE);
      TLB:   if (tlb_flush_ack) state_next = pipe_q ? PIPE : DONE;
      PIPE:  if (pipe_flush_ack) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      src_q   <= SRC_NONE;
      tlb_q   <= 1'b0;
      pipe_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        src_q   <= grant_src;
        tlb_q   <= grant_tlb;
        pipe_q  <= grant_pipe;
        fault_q <= grant_fault;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (state == IDLE) begin
      index_q <= grant_index;
      data_q  <= grant_data;
    end
  end

  assign cr_write_enable = (state == WRITE);
  assign cr_write_index  = cr_write_enable ? index_q : 3'd0;
  assign cr_write_data   = cr_write_enable ? data_q : 32'd0;
  assign tlb_flush_req   = (state == TLB);
  assign pipe_flush_req  = (state == PIPE);
  assign busy            = (state != IDLE);
  assign pf_ack          = (state == DONE) && (src_q == SRC_PF);
  assign ts_ack          = (state == DONE) && (src_q == SRC_TS);
  assign ex_ack          = (state == DONE) && (src_q == SRC_EX);
  assign ex_fault        = ex_ack && fault_q;

endmodule
